// File: rtl/operand_fetch_pkg.sv
// Shared pipeline constants and the forwarding-source encoding.
// Both the operand-fetch stage and its forwarding muxes use these definitions.
package operand_fetch_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 3'd0;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_src_e;

  // A producer whose destination is R0 never matches a source register.
  function automatic logic reg_match(input logic             we,
                                     input logic [REG_W-1:0] prod_rd,
                                     input logic [REG_W-1:0] src);
    return we && (prod_rd != REG_ZERO) && (prod_rd == src);
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side request and execute-side operand bundle of the operand-fetch stage.
// The master is the decode/execute environment; the slave is the stage itself.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic              id_valid;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_W-1:0]  id_rd;
  logic              id_rd_we;
  logic              id_is_load;
  logic              id_use_imm;
  logic [DATA_W-1:0] id_imm;
  logic              stall_out;

  logic              op_valid;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic [REG_W-1:0]  op_rd;
  logic              op_rd_we;
  logic              op_is_load;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, id_use_imm, id_imm,
    input  stall_out,
    input  op_valid, op_a, op_b, op_rd, op_rd_we, op_is_load
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_rd_we, id_is_load, id_use_imm, id_imm,
    output stall_out,
    output op_valid, op_a, op_b, op_rd, op_rd_we, op_is_load
  );

endinterface

// File: rtl/operand_fetch_fwd_select.sv
// Per-operand forwarding priority mux: R0, then EX (non-load), MEM, WB, register file.
// WB must be considered because the file returns the stale value on a same-edge write/read.
module fwd_select
  import operand_fetch_pkg::*;
(
  input  logic [REG_W-1:0]  src,
  input  logic              ex_we,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_we,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data
);

  fwd_src_e sel;

  always_comb begin
    sel = FWD_RF;
    if (src == REG_ZERO)
      sel = FWD_ZERO;
    else if (reg_match(ex_we, ex_rd, src) && !ex_is_load)
      sel = FWD_EX;
    else if (reg_match(mem_we, mem_rd, src))
      sel = FWD_MEM;
    else if (reg_match(wb_we, wb_rd, src))
      sel = FWD_WB;
  end

  always_comb begin
    data = rf_data;
    case (sel)
      FWD_ZERO: data = '0;
      FWD_EX:   data = ex_data;
      FWD_MEM:  data = mem_data;
      FWD_WB:   data = wb_data;
      default:  data = rf_data;
    endcase
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: S1 holds the accepted decode fields while the register file reads,
// OUT registers the resolved operands for execute. Load-use hazards hold S1 and bubble OUT.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  operand_fetch_if.slave    ofi,
  output logic [REG_W-1:0]  RA,
  output logic [REG_W-1:0]  RB,
  input  logic [DATA_W-1:0] BusA,
  input  logic [DATA_W-1:0] BusB,
  input  logic [REG_W-1:0]  fwd_ex_rd,
  input  logic [REG_W-1:0]  fwd_mem_rd,
  input  logic [REG_W-1:0]  fwd_wb_rd,
  input  logic              fwd_ex_we,
  input  logic              fwd_mem_we,
  input  logic              fwd_wb_we,
  input  logic              fwd_ex_is_load,
  input  logic [DATA_W-1:0] fwd_ex_data,
  input  logic [DATA_W-1:0] fwd_mem_data,
  input  logic [DATA_W-1:0] fwd_wb_data
);

  logic              s1_valid;
  logic [REG_W-1:0]  s1_rs1;
  logic [REG_W-1:0]  s1_rs2;
  logic              s1_use_rs1;
  logic              s1_use_rs2;
  logic [REG_W-1:0]  s1_rd;
  logic              s1_rd_we;
  logic              s1_is_load;
  logic              s1_use_imm;
  logic [DATA_W-1:0] s1_imm;

  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] res_a;
  logic [DATA_W-1:0] res_b;

  always_comb begin
    hazard = s1_valid && fwd_ex_is_load &&
             ((s1_use_rs1 && reg_match(fwd_ex_we, fwd_ex_rd, s1_rs1)) ||
              (s1_use_rs2 && reg_match(fwd_ex_we, fwd_ex_rd, s1_rs2)));
  end

  assign ofi.stall_out = hazard && !flush;
  assign accept        = ofi.id_valid && !ofi.stall_out && !flush;

  // While held, the file re-reads S1's sources so BusA/BusB stay current.
  assign RA = ofi.stall_out ? s1_rs1 : ofi.id_rs1;
  assign RB = ofi.stall_out ? s1_rs2 : ofi.id_rs2;

  fwd_select u_fwd_a (
    .src        (s1_rs1),
    .ex_we      (fwd_ex_we),
    .ex_rd      (fwd_ex_rd),
    .ex_is_load (fwd_ex_is_load),
    .ex_data    (fwd_ex_data),
    .mem_we     (fwd_mem_we),
    .mem_rd     (fwd_mem_rd),
    .mem_data   (fwd_mem_data),
    .wb_we      (fwd_wb_we),
    .wb_rd      (fwd_wb_rd),
    .wb_data    (fwd_wb_data),
    .rf_data    (BusA),
    .data       (res_a)
  );

  fwd_select u_fwd_b (
    .src        (s1_rs2),
    .ex_we      (fwd_ex_we),
    .ex_rd      (fwd_ex_rd),
    .ex_is_load (fwd_ex_is_load),
    .ex_data    (fwd_ex_data),
    .mem_we     (fwd_mem_we),
    .mem_rd     (fwd_mem_rd),
    .mem_data   (fwd_mem_data),
    .wb_we      (fwd_wb_we),
    .wb_rd      (fwd_wb_rd),
    .wb_data    (fwd_wb_data),
    .rf_data    (BusB),
    .data       (res_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_rs1     <= '0;
      s1_rs2     <= '0;
      s1_use_rs1 <= 1'b0;
      s1_use_rs2 <= 1'b0;
      s1_rd      <= '0;
      s1_rd_we   <= 1'b0;
      s1_is_load <= 1'b0;
      s1_use_imm <= 1'b0;
      s1_imm     <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (!hazard) begin
      s1_valid <= accept;
      if (accept) begin
        s1_rs1     <= ofi.id_rs1;
        s1_rs2     <= ofi.id_rs2;
        s1_use_rs1 <= ofi.id_use_rs1;
        s1_use_rs2 <= ofi.id_use_rs2;
        s1_rd      <= ofi.id_rd;
        s1_rd_we   <= ofi.id_rd_we;
        s1_is_load <= ofi.id_is_load;
        s1_use_imm <= ofi.id_use_imm;
        s1_imm     <= ofi.id_imm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofi.op_valid   <= 1'b0;
      ofi.op_a       <= '0;
      ofi.op_b       <= '0;
      ofi.op_rd      <= '0;
      ofi.op_rd_we   <= 1'b0;
      ofi.op_is_load <= 1'b0;
    end else if (flush || hazard) begin
      ofi.op_valid <= 1'b0;
      ofi.op_rd_we <= 1'b0;
    end else begin
      ofi.op_valid   <= s1_valid;
      ofi.op_a       <= res_a;
      ofi.op_b       <= s1_use_imm ? s1_imm : res_b;
      ofi.op_rd      <= s1_rd;
      // An empty slot must never look like a register write to later stages.
      ofi.op_rd_we   <= s1_rd_we && s1_valid;
      ofi.op_is_load <= s1_is_load;
    end
  end

endmodule
